fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 103 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
// Holds the FSM state enum and the ring-index helper used by the round-robin search.
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MAX_BURST  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Index reached by stepping 'off' places past 'base' around a ring of n slots.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request after last_grant, wrapping.
// A request equal to last_grant is considered last, so it only wins when it is alone.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       any_req
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'(wrap_idx(int'(last_grant), off, NUM_REQ));
            if (!any_req && req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Grants one requester at a time a burst of up to MAX_BURST writes into a downstream FIFO.
// Handshake and write data are combinational from the registered owner; arbitration takes one IDLE cycle.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] rr_winner;
    logic             rr_any;
    logic             owner_valid;
    logic             xfer;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_words;

    assign req_words = req_data;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .winner     (rr_winner),
        .any_req    (rr_any)
    );

    // Async reset drops state_q to IDLE, which zeroes busy/ready/w_en in the same instant.
    assign busy         = (state_q == BURST);
    assign owner_valid  = req_valid[grant_q];
    assign xfer         = busy & owner_valid & ~fifo_full;
    assign fifo_w_en    = xfer;
    assign fifo_data_in = req_words[grant_q];
    assign grant_id     = grant_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
        assign req_ready[g] = busy && (grant_q == IDX_W'(g)) && !fifo_full;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rr_any) begin
                    grant_d = rr_winner;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                // Owner dropping valid releases the grant even while the FIFO is full.
                if (!owner_valid) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(MAX_BURST)) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: cycle table for basic bursts/releases, hand sequences for stalls and reset,
// and a MAX_BURST=1 instance checked against a round-robin ordering scoreboard.
module tb_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         fifo_full = 1'b0;
    logic         fifo_w_en;
    logic [31:0]  fifo_data_in;
    logic [1:0]   grant_id;
    logic         busy;

    logic [3:0]   req_valid1 = '0;
    logic [127:0] req_data1 = '0;
    logic [3:0]   req_ready1;
    logic         fifo_full1 = 1'b0;
    logic         fifo_w_en1;
    logic [31:0]  fifo_data_in1;
    logic [1:0]   grant_id1;
    logic         busy1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
        .fifo_data_in(fifo_data_in), .grant_id(grant_id), .busy(busy)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_data(req_data1),
        .req_ready(req_ready1), .fifo_full(fifo_full1), .fifo_w_en(fifo_w_en1),
        .fifo_data_in(fifo_data_in1), .grant_id(grant_id1), .busy(busy1)
    );

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic        full;
        logic [31:0] d0;
        logic        busy;
        logic [1:0]  grant;
        logic [3:0]  ready;
        logic        wen;
        logic [31:0] data;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic f, input logic [31:0] d0,
                                input logic b, input logic [1:0] g, input logic [3:0] rdy,
                                input logic w, input logic [31:0] dat);
        vec_t t;
        t.rst_n = r; t.valid = v; t.full = f; t.d0 = d0;
        t.busy = b; t.grant = g; t.ready = rdy; t.wen = w; t.data = dat;
        return t;
    endfunction

    function automatic logic [31:0] word(input int i, input int k);
        return 32'hC000_0000 | (32'(i) << 8) | 32'(k);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0; req_valid = '0; fifo_full = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_out(input string tag, input logic b, input logic [1:0] g,
                           input logic [3:0] rdy, input logic w);
        check({tag, " busy"}, 32'(busy), 32'(b));
        check({tag, " grant"}, 32'(grant_id), 32'(g));
        check({tag, " ready"}, 32'(req_ready), 32'(rdy));
        check({tag, " wen"}, 32'(fifo_w_en), 32'(w));
    endtask

    int sent[4];
    int last_w;
    int writes;
    int e;
    logic prev_wen;

    initial begin
        // Single-owner bursts with a reload, valid-drop releases, round-robin hand-off 2 -> 3.
        vecs[0]  = mk(0, 4'b0000, 0, 32'h00, 0, 0, 4'b0000, 0, 32'h00);
        vecs[1]  = mk(1, 4'b0001, 0, 32'hA0, 0, 0, 4'b0000, 0, 32'h00);
        vecs[2]  = mk(1, 4'b0001, 0, 32'hA0, 1, 0, 4'b0001, 1, 32'hA0);
        vecs[3]  = mk(1, 4'b0001, 0, 32'hA1, 1, 0, 4'b0001, 1, 32'hA1);
        vecs[4]  = mk(1, 4'b0001, 0, 32'hA2, 1, 0, 4'b0001, 1, 32'hA2);
        vecs[5]  = mk(1, 4'b0001, 0, 32'hA3, 1, 0, 4'b0001, 1, 32'hA3);
        vecs[6]  = mk(1, 4'b0001, 0, 32'hA4, 0, 0, 4'b0000, 0, 32'h00);
        vecs[7]  = mk(1, 4'b0001, 0, 32'hA4, 1, 0, 4'b0001, 1, 32'hA4);
        vecs[8]  = mk(1, 4'b0001, 0, 32'hA5, 1, 0, 4'b0001, 1, 32'hA5);
        vecs[9]  = mk(1, 4'b0000, 0, 32'h00, 1, 0, 4'b0001, 0, 32'h00);
        vecs[10] = mk(1, 4'b0000, 0, 32'h00, 0, 0, 4'b0000, 0, 32'h00);
        vecs[11] = mk(1, 4'b0100, 0, 32'h00, 0, 0, 4'b0000, 0, 32'h00);
        vecs[12] = mk(1, 4'b1110, 0, 32'h00, 1, 2, 4'b0100, 1, 32'h22);
        vecs[13] = mk(1, 4'b1110, 0, 32'h00, 1, 2, 4'b0100, 1, 32'h22);
        vecs[14] = mk(1, 4'b1010, 0, 32'h00, 1, 2, 4'b0100, 0, 32'h00);
        vecs[15] = mk(1, 4'b1010, 0, 32'h00, 0, 2, 4'b0000, 0, 32'h00);
        vecs[16] = mk(1, 4'b1010, 0, 32'h00, 1, 3, 4'b1000, 1, 32'h33);
        vecs[17] = mk(1, 4'b0000, 0, 32'h00, 1, 3, 4'b1000, 0, 32'h00);
        vecs[18] = mk(1, 4'b0000, 0, 32'h00, 0, 3, 4'b0000, 0, 32'h00);

        req_data = {32'h33, 32'h22, 32'h11, 32'h00};
        for (int i = 0; i < 19; i++) begin
            tick();
            rst_n = vecs[i].rst_n;
            req_valid = vecs[i].valid;
            fifo_full = vecs[i].full;
            req_data[31:0] = vecs[i].d0;
            #1;
            chk_out($sformatf("v%0d", i), vecs[i].busy, vecs[i].grant, vecs[i].ready, vecs[i].wen);
            if (vecs[i].wen) check($sformatf("v%0d data", i), fifo_data_in, vecs[i].data);
        end

        // All requesters valid: bursts 0,1,2,3,0 of four beats, one idle cycle before each.
        do_reset();
        req_valid = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            if (b > 0) tick();
            #1;
            check($sformatf("rr%0d idle busy", b), 32'(busy), 32'd0);
            check($sformatf("rr%0d idle wen", b), 32'(fifo_w_en), 32'd0);
            for (int k = 0; k < 4; k++) begin
                tick();
                #1;
                check($sformatf("rr%0d.%0d grant", b, k), 32'(grant_id), 32'(b % 4));
                check($sformatf("rr%0d.%0d wen", b, k), 32'(fifo_w_en), 32'd1);
            end
        end

        // FIFO full for five cycles after beat 2; grant held, beats 3-4 follow.
        do_reset();
        req_valid = 4'b0001;
        req_data[31:0] = 32'hB0;
        #1;
        chk_out("st idle", 0, 0, 4'b0000, 0);
        for (int c = 1; c <= 2; c++) begin
            tick();
            #1;
            chk_out($sformatf("st beat%0d", c), 1, 0, 4'b0001, 1);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            fifo_full = 1'b1;
            #1;
            chk_out($sformatf("st full%0d", c), 1, 0, 4'b0000, 0);
        end
        for (int c = 3; c <= 4; c++) begin
            tick();
            fifo_full = 1'b0;
            #1;
            chk_out($sformatf("st beat%0d", c), 1, 0, 4'b0001, 1);
            check($sformatf("st data%0d", c), fifo_data_in, 32'hB0);
        end
        tick();
        #1;
        chk_out("st done", 0, 0, 4'b0000, 0);

        // Reset mid-burst: write suppressed at once; afterwards requester 0 wins first.
        do_reset();
        req_valid = 4'b0010;
        #1;
        chk_out("rs idle", 0, 0, 4'b0000, 0);
        tick();
        #1;
        chk_out("rs beat1", 1, 1, 4'b0010, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("rs asserted", 0, 0, 4'b0000, 0);
        tick();
        rst_n = 1'b1;
        req_valid = 4'b0011;
        #1;
        chk_out("rs release", 0, 0, 4'b0000, 0);
        tick();
        #1;
        chk_out("rs first", 1, 0, 4'b0001, 1);

        // MAX_BURST=1 scoreboard: six words per requester, random FIFO back-pressure.
        do_reset();
        req_valid = '0;
        for (int i = 0; i < 4; i++) sent[i] = 0;
        last_w = 3;
        writes = 0;
        prev_wen = 1'b0;
        for (int cyc = 0; cyc < 400 && writes < 24; cyc++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                req_valid1[i] = (sent[i] < 6);
                req_data1[i*32 +: 32] = word(i, sent[i]);
            end
            fifo_full1 = ($urandom_range(0, 3) == 0);
            #1;
            if (fifo_w_en1) begin
                e = last_w;
                for (int off = 1; off <= 4; off++) begin
                    if (sent[(last_w + off) % 4] < 6 && e == last_w) e = (last_w + off) % 4;
                end
                if (sent[e] >= 6) e = last_w;
                check("sb order", fifo_data_in1, word(e, sent[e]));
                check("sb spacing", 32'(prev_wen), 32'd0);
                sent[e]++;
                last_w = e;
                writes++;
            end
            prev_wen = fifo_w_en1;
        end
        check("sb count", 32'(writes), 32'd24);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
